// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel-stream blocks (burst packer and the
// burst-to-pixel sequentializer).
//   TUSER_SOF : tuser bit marking the first pixel of a frame
//   TUSER_EOL : tuser bit marking the last pixel of a line
package pixel_stream_pkg;

  localparam int unsigned TUSER_SOF = 0;
  localparam int unsigned TUSER_EOL = 2;

endpackage

// File: rtl/burst_out_reg.sv
// Output holding register for the burst packer with AXI-stream valid/ready.
//   clk, srst         : clock, synchronous active-high reset
//   load              : capture load_* this cycle (only when can_load is high)
//   load_data/user/keep : burst contents to capture
//   can_load          : register is empty or draining this cycle
//   m_axis_*          : burst master interface
module burst_out_reg #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 4,
  parameter int unsigned KEEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [USER_WIDTH-1:0] load_user,
  input  logic [KEEP_WIDTH-1:0] load_keep,
  output logic                  can_load,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep
);

  assign can_load = ~m_axis_tvalid | m_axis_tready;

  // Payload only changes on load, and load is only issued when the register is
  // empty or draining, so the payload is stable while stalled.
  always_ff @(posedge clk) begin
    if (srst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tkeep  <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_data;
      m_axis_tuser  <= load_user;
      m_axis_tkeep  <= load_keep;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/burst_packer.sv
// Packs a single-pixel AXI stream into multi-pixel bursts.
//   clk, srst          : clock, synchronous active-high reset
//   s_axis_*           : pixel slave (tuser SOF/EOL flags)
//   m_axis_*           : burst master, lane 0 = earliest pixel, tkeep per lane
//   line_err           : one-cycle pulse on a malformed line / frame
//   cnt_col, cnt_row   : position of the next expected input pixel
module burst_packer
  import pixel_stream_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH  = 16,
  parameter int unsigned PIXELS_PER_BURST = 16,
  parameter int unsigned USER_WIDTH       = 4,
  parameter int unsigned IN_COLS          = 160,
  parameter int unsigned IN_ROWS          = 100
) (
  input  logic                                         clk,
  input  logic                                         srst,
  input  logic                                         s_axis_tvalid,
  output logic                                         s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]                   s_axis_tdata,
  input  logic [USER_WIDTH-1:0]                        s_axis_tuser,
  output logic                                         m_axis_tvalid,
  input  logic                                         m_axis_tready,
  output logic [PIXEL_BIT_WIDTH*PIXELS_PER_BURST-1:0]  m_axis_tdata,
  output logic [USER_WIDTH-1:0]                        m_axis_tuser,
  output logic [PIXELS_PER_BURST-1:0]                  m_axis_tkeep,
  output logic                                         line_err,
  output logic [$clog2(IN_COLS)-1:0]                   cnt_col,
  output logic [$clog2(IN_ROWS)-1:0]                   cnt_row
);

  localparam int unsigned DataW = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
  localparam int unsigned LaneW = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
  localparam int unsigned ColW  = $clog2(IN_COLS);
  localparam int unsigned RowW  = $clog2(IN_ROWS);
  localparam logic [LaneW-1:0] LaneLast = LaneW'(PIXELS_PER_BURST - 1);
  localparam logic [ColW-1:0]  ColLast  = ColW'(IN_COLS - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(IN_ROWS - 1);

  localparam logic [0:0] StFill = 1'b0;
  localparam logic [0:0] StPend = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [LaneW-1:0]      lane_idx_q, lane_idx_d;
  logic [DataW-1:0]      acc_q, acc_d;
  logic                  sof_seen_q, sof_seen_d;
  logic [PIXELS_PER_BURST-1:0] pend_keep_q, pend_keep_d;
  logic [USER_WIDTH-1:0] pend_user_q, pend_user_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [RowW-1:0]       row_q, row_d;
  logic                  line_err_q, line_err_d;

  logic                  accept, pix_sof, pix_eol, close;
  logic [LaneW-1:0]      lane;
  logic [DataW-1:0]      filled;
  logic [PIXELS_PER_BURST-1:0] keep;
  logic [USER_WIDTH-1:0] burst_user;
  logic [ColW-1:0]       col_base;
  logic [RowW-1:0]       row_base;

  logic                  load, can_load;
  logic [DataW-1:0]      load_data;
  logic [USER_WIDTH-1:0] load_user;
  logic [PIXELS_PER_BURST-1:0] load_keep;
  logic                  unused_tuser;

  assign unused_tuser  = ^s_axis_tuser;
  assign s_axis_tready = (state_q == StFill);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pix_sof       = s_axis_tuser[TUSER_SOF];
  assign pix_eol       = s_axis_tuser[TUSER_EOL];

  // Burst under construction including the current pixel. A frame start
  // throws away any partial lanes and restarts at lane 0. The accumulator is
  // cleared after every emitted burst, so unfilled lanes are already zero.
  always_comb begin
    lane   = pix_sof ? '0 : lane_idx_q;
    filled = pix_sof ? '0 : acc_q;
    filled[lane*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = s_axis_tdata;
    for (int i = 0; i < int'(PIXELS_PER_BURST); i++) begin
      keep[i] = (i <= int'(lane));
    end
    burst_user            = '0;
    burst_user[TUSER_SOF] = sof_seen_q | pix_sof;
    burst_user[TUSER_EOL] = pix_eol;
    close                 = (lane == LaneLast) | pix_eol;
    col_base              = pix_sof ? '0 : col_q;
    row_base              = pix_sof ? '0 : row_q;
  end

  always_comb begin
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    acc_d       = acc_q;
    sof_seen_d  = sof_seen_q;
    pend_keep_d = pend_keep_q;
    pend_user_d = pend_user_q;
    col_d       = col_q;
    row_d       = row_q;
    line_err_d  = 1'b0;
    load        = 1'b0;
    load_data   = acc_q;
    load_user   = pend_user_q;
    load_keep   = pend_keep_q;

    if (accept) begin
      if (pix_sof && (lane_idx_q != '0)) line_err_d = 1'b1;
      if (pix_eol) begin
        if (col_base != ColLast) line_err_d = 1'b1;
        col_d = '0;
        row_d = (row_base == RowLast) ? '0 : row_base + RowW'(1);
      end else if (col_base == ColLast) begin
        // Line ran past its nominal width: flag it and restart the column.
        line_err_d = 1'b1;
        col_d      = '0;
        row_d      = row_base;
      end else begin
        col_d = col_base + ColW'(1);
        row_d = row_base;
      end
    end

    case (state_q)
      StFill: begin
        if (accept) begin
          if (close) begin
            lane_idx_d = '0;
            sof_seen_d = 1'b0;
            if (can_load) begin
              load      = 1'b1;
              load_data = filled;
              load_user = burst_user;
              load_keep = keep;
              acc_d     = '0;
            end else begin
              // Park the closed burst in the accumulator until the output frees.
              state_d     = StPend;
              acc_d       = filled;
              pend_keep_d = keep;
              pend_user_d = burst_user;
            end
          end else begin
            lane_idx_d = lane + LaneW'(1);
            acc_d      = filled;
            sof_seen_d = sof_seen_q | pix_sof;
          end
        end
      end
      StPend: begin
        if (can_load) begin
          load    = 1'b1;
          acc_d   = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= StFill;
      lane_idx_q  <= '0;
      acc_q       <= '0;
      sof_seen_q  <= 1'b0;
      pend_keep_q <= '0;
      pend_user_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      line_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      acc_q       <= acc_d;
      sof_seen_q  <= sof_seen_d;
      pend_keep_q <= pend_keep_d;
      pend_user_q <= pend_user_d;
      col_q       <= col_d;
      row_q       <= row_d;
      line_err_q  <= line_err_d;
    end
  end

  assign line_err = line_err_q;
  assign cnt_col  = col_q;
  assign cnt_row  = row_q;

  burst_out_reg #(
    .DATA_WIDTH (DataW),
    .USER_WIDTH (USER_WIDTH),
    .KEEP_WIDTH (PIXELS_PER_BURST)
  ) u_out_reg (
    .clk           (clk),
    .srst          (srst),
    .load          (load),
    .load_data     (load_data),
    .load_user     (load_user),
    .load_keep     (load_keep),
    .can_load      (can_load),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tkeep  (m_axis_tkeep)
  );

endmodule

// File: doc/burst_packer.md
BURST_PACKER -- requirements
Module: burst_packer

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 16, bits per pixel.
REQ-002 SHALL have parameter PIXELS_PER_BURST, default 16, pixels per output beat (power of 2).
REQ-003 SHALL have parameter USER_WIDTH, default 4, tuser width on both sides.
REQ-004 SHALL have parameter IN_COLS, default 160, nominal pixels per line.
REQ-005 SHALL have parameter IN_ROWS, default 100, nominal lines per frame.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port srst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports s_axis_tvalid / s_axis_tready, input / output, 1 each, single-pixel slave handshake.
REQ-009 SHALL have port s_axis_tdata, input, PIXEL_BIT_WIDTH, one pixel.
REQ-010 SHALL have port s_axis_tuser, input, USER_WIDTH, bit0 = frame start (first pixel), bit2 = line end (last pixel of line).
REQ-011 SHALL have ports m_axis_tvalid / m_axis_tready, output / input, 1 each, burst master handshake.
REQ-012 SHALL have port m_axis_tdata, output, PIXEL_BIT_WIDTH*PIXELS_PER_BURST, lane i at bits [(i+1)*PIXEL_BIT_WIDTH-1 : i*PIXEL_BIT_WIDTH], lane 0 = earliest pixel.
REQ-013 SHALL have port m_axis_tuser, output, USER_WIDTH, bit0 = burst holds frame-start pixel, bit2 = burst holds line-end pixel, other bits 0.
REQ-014 SHALL have port m_axis_tkeep, output, PIXELS_PER_BURST, lane i valid.
REQ-015 SHALL have port line_err, output, 1, one-cycle pulse on malformed line.
REQ-016 SHALL have ports cnt_col / cnt_row, output, $clog2(IN_COLS) / $clog2(IN_ROWS), current input pixel position.

Function
REQ-017 SHALL accumulate accepted pixels into lane index lane_idx, incrementing per s_axis handshake.
REQ-018 SHALL close a burst when lane_idx == PIXELS_PER_BURST-1 or the accepted pixel has tuser bit2.
REQ-019 SHALL on a partial (line-end) close zero unfilled lanes and clear their tkeep bits; full bursts SHALL have tkeep all ones.
REQ-020 SHALL use states FILL (accepting) and PEND (closed burst awaiting output register); FILL->PEND when a burst closes while m_axis_tvalid=1 and m_axis_tready=0; PEND->FILL when the output register frees.
REQ-021 SHALL drive s_axis_tready = 1 in FILL and 0 in PEND.
REQ-022 SHALL load a closed burst into the output register in the closing cycle if it is empty or draining that cycle, giving m_axis_tvalid the cycle after the closing pixel handshake (latency 1).
REQ-023 SHALL hold m_axis_tdata/tuser/tkeep stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 SHALL sustain one pixel per cycle with m_axis_tready=1 continuously (no bubbles).
REQ-025 SHALL, on a frame-start pixel with lane_idx != 0, discard prior partial lanes, place the pixel in lane 0, and pulse line_err.
REQ-026 SHALL reset cnt_col to 0 and cnt_row to 0 on a frame-start pixel; cnt_col increments per pixel, clears after line end; cnt_row increments on line end, wrapping to 0 after IN_ROWS-1.
REQ-027 SHALL pulse line_err when a line-end pixel arrives with cnt_col != IN_COLS-1, or when cnt_col would exceed IN_COLS-1 without line end; the burst is still emitted.
REQ-028 SHALL set output tuser bit0 on exactly the first burst after a frame-start pixel.

Reset
REQ-029 SHALL on srst clear lane_idx, cnt_col, cnt_row, accumulator, state to FILL, m_axis_tvalid=0, m_axis_tdata/tuser/tkeep=0, line_err=0.
REQ-030 SHALL give srst priority over any simultaneous handshake; partial or pending bursts mid-operation SHALL be dropped.
REQ-031 SHALL assert s_axis_tready=1 the first cycle after srst deasserts.

Structure
REQ-032 SHALL take tuser bit indices (TUSER_SOF=0, TUSER_EOL=2) from a shared package pixel_stream_pkg, also used by the burst-to-pixel sequentializer.
REQ-033 SHALL implement the output register plus its valid/ready logic as sub-module burst_out_reg; counters and FSM stay in burst_packer.

Verification
REQ-034 SHALL test 160-pixel line, values 0..159, tready=1: 10 bursts, burst k lane i = 16k+i, tkeep=FFFF, tuser bit2 only on burst 9, no stalls.
REQ-035 SHALL test 20-pixel line with line end on pixel 19: second burst lanes 0-3 = 16..19, lanes 4-15 = 0, tkeep=000F, line_err pulses once.
REQ-036 SHALL test m_axis_tready=0 for 40 cycles during streaming: s_axis_tready drops one cycle after second burst closes, output data held, no pixel lost or duplicated.
REQ-037 SHALL test frame start on lane 5 mid-burst: prior 5 pixels dropped, new pixel in lane 0, line_err pulse, emitted tuser bit0=1, cnt_row=0.
REQ-038 SHALL test srst asserted with a pending burst: next cycle m_axis_tvalid=0, state FILL, counters 0; next burst starts at lane 0.
